// File: rtl/periph_arb_pkg.sv
// Shared types and helpers for the peripheral SEND arbiter.
// The round-robin picker here is bypassed when PERIPH_ARB_FIXED_PRIO_EN is defined.
package periph_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned MAX_REQ    = 8;

  // Rotate requests so index ptr sits at bit 0, take the lowest set bit, rotate back.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [2:0]         ptr,
                                                 input int                 n);
    logic [MAX_REQ-1:0] rot;
    logic [MAX_REQ-1:0] first;
    logic [MAX_REQ-1:0] pick;
    logic               found;
    rot   = '0;
    first = '0;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n) rot[k] = req[(k + int'(ptr)) % n];
    end
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n && rot[k] && !found) begin
        first[k] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n) pick[(k + int'(ptr)) % n] = first[k];
    end
    return pick;
  endfunction

endpackage

// File: rtl/periph_send_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot winner among req_i, searching upward from ptr_i.
module periph_rr_picker
  import periph_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o
);

  assign grant_o = NUM_REQ'(rr_pick(MAX_REQ'(req_i), 3'(ptr_i), NUM_REQ));

endmodule

// File: rtl/periph_send_arbiter.sv
// Round-robin sharing of one peripheral SEND/data port among NUM_REQ requesters.
// Define PERIPH_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no rr_ptr).
module periph_send_arbiter
  import periph_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned HOLD_CYCLES = 1,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic                      clk_arb,
  input  logic                      rst_arb,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic                      busy,
  output logic                      send_per,
  output logic [DATA_W-1:0]         data_per
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [NUM_REQ-1:0]  grant_q;
  logic [DATA_W-1:0]   data_q;
  logic [NUM_REQ-1:0]  win_oh;
  logic [DATA_W-1:0]   win_data;
  logic                hold_last, gap_last, arb_en, arb_fire;

  assign hold_last = (hold_cnt_q == HOLD_LAST);
  assign gap_last  = (gap_cnt_q == GAP_LAST);
  assign arb_en    = (state_q == IDLE) || (state_q == GAP && gap_last);
  assign arb_fire  = arb_en && (|req);

`ifdef PERIPH_ARB_FIXED_PRIO_EN
  assign win_oh = req & (~req + 1'b1);
`else
  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] win_idx;

  periph_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .grant_o (win_oh)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) win_idx = PTR_W'(i);
    end
    rr_ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge clk_arb or negedge rst_arb) begin
    if (!rst_arb)      rr_ptr_q <= '0;
    else if (arb_fire) rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) win_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_arb or negedge rst_arb) begin
    if (!rst_arb) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req) state_d = XFER;
      XFER:    if (hold_last) state_d = GAP;
      GAP:     if (gap_last) state_d = (|req) ? XFER : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    send_per = (state_q == XFER);
    busy     = (state_q != IDLE);
    grant    = (state_q == XFER) ? grant_q : '0;
    done     = (state_q == XFER && hold_last) ? grant_q : '0;
  end

  // Counters restart from 0 whenever their state is (re)entered.
  assign hold_cnt_d = (state_q == XFER && !hold_last) ? hold_cnt_q + 1'b1 : '0;
  assign gap_cnt_d  = (state_q == GAP && !gap_last)   ? gap_cnt_q + 1'b1  : '0;

  // NOTE: the data latch is reset because data_per must read 0 during reset.
  always_ff @(posedge clk_arb or negedge rst_arb) begin
    if (!rst_arb) begin
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
      grant_q    <= '0;
      data_q     <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      if (arb_fire) begin
        grant_q <= win_oh;
        data_q  <= win_data;
      end
    end
  end

  // The last word stays on data_per through GAP and IDLE; the peripheral samples it late.
  assign data_per = data_q;

endmodule

// File: tb/tb_periph_send_arbiter.sv
// Directed self-checking bench for periph_send_arbiter (NUM_REQ=4, HOLD=2, GAP=1).
// Exercises the fixed-priority path instead of round-robin when PERIPH_ARB_FIXED_PRIO_EN is defined.
module tb_periph_send_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;

  logic                      clk_arb;
  logic                      rst_arb;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        done;
  logic                      busy;
  logic                      send_per;
  logic [DATA_W-1:0]         data_per;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] dv [NUM_REQ] = '{32'hA0A0_A0A0, 32'hB1B1_B1B1, 32'hC2C2_C2C2, 32'hD3D3_D3D3};

  periph_send_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .DATA_W      (DATA_W),
    .HOLD_CYCLES (2),
    .GAP_CYCLES  (1)
  ) dut (
    .clk_arb  (clk_arb),
    .rst_arb  (rst_arb),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .done     (done),
    .busy     (busy),
    .send_per (send_per),
    .data_per (data_per)
  );

  initial clk_arb = 1'b0;
  always #5 clk_arb = ~clk_arb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_arb);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'h0);
    check({tag, "_done"},  32'(done),  32'h0);
    check({tag, "_busy"},  32'(busy),  32'h0);
    check({tag, "_send"},  32'(send_per), 32'h0);
    check({tag, "_data"},  data_per,   32'h0);
  endtask

  initial begin
    rst_arb  = 1'b0;
    req      = '0;
    req_data = '0;
    #2;
    check_idle_zero("rst_init");
    tick;
    tick;
    rst_arb = 1'b1;

    // Single transfer from requester 2 (rr_ptr=0 -> search 0,1,2).
    req_data[2*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
    req = 4'b0100;
    tick;
    check("single_c1_send",  32'(send_per), 32'h1);
    check("single_c1_grant", 32'(grant),    32'h4);
    check("single_c1_data",  data_per,      32'hDEAD_BEEF);
    check("single_c1_done",  32'(done),     32'h0);
    tick;
    check("single_c2_send",  32'(send_per), 32'h1);
    check("single_c2_done",  32'(done),     32'h4);
    tick;
    check("single_c3_send",  32'(send_per), 32'h0);
    check("single_c3_grant", 32'(grant),    32'h0);
    check("single_c3_busy",  32'(busy),     32'h1);
    req = '0;
    tick;
    check("single_c4_busy",  32'(busy),     32'h0);
    check("single_c4_data",  data_per,      32'hDEAD_BEEF);

    // Mid-transfer changes: req dropped and data changed after latch.
    req_data[1*DATA_W +: DATA_W] = 32'h1111_1111;
    req = 4'b0010;
    tick;
    check("mid_c1_data", data_per, 32'h1111_1111);
    req = '0;
    req_data[1*DATA_W +: DATA_W] = 32'h2222_2222;
    tick;
    check("mid_c2_send", 32'(send_per), 32'h1);
    check("mid_c2_data", data_per,      32'h1111_1111);
    check("mid_c2_done", 32'(done),     32'h2);
    tick;
    tick;
    check("mid_c4_busy", 32'(busy), 32'h0);

    // Reset asserted mid-XFER forces outputs low immediately.
    req_data[0*DATA_W +: DATA_W] = 32'hAAAA_0000;
    req = 4'b0001;
    tick;
    check("rstx_pre_send", 32'(send_per), 32'h1);
    rst_arb = 1'b0;
    #1;
    check_idle_zero("rstx");
    rst_arb = 1'b1;

    for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = dv[i];
    req = 4'b1111;

`ifdef PERIPH_ARB_FIXED_PRIO_EN
    tick;
    check("fp_first_grant", 32'(grant), 32'h1);
    tick;
    tick;
    req = 4'b1010;
    tick;
    for (int w = 0; w < 3; w++) begin
      check($sformatf("fp_w%0d_grant", w), 32'(grant), 32'h2);
      check($sformatf("fp_w%0d_data", w),  data_per,    dv[1]);
      tick;
      check($sformatf("fp_w%0d_done", w),  32'(done),   32'h2);
      tick;
      if (w == 2) req = 4'b1000;
      tick;
    end
    check("fp_g3_grant", 32'(grant), 32'h8);
    check("fp_g3_data",  data_per,   dv[3]);
    tick;
    check("fp_g3_done",  32'(done),  32'h8);
    tick;
    req = '0;
    tick;
    check("fp_end_busy", 32'(busy), 32'h0);
`else
    tick;
    // Round-robin 0,1,2,3 then wrap to 0 with req=0011 after granting 3.
    for (int k = 0; k < 5; k++) begin
      int idx;
      idx = k % NUM_REQ;
      check($sformatf("rr_k%0d_grant", k), 32'(grant),    32'(1 << idx));
      check($sformatf("rr_k%0d_send", k),  32'(send_per), 32'h1);
      check($sformatf("rr_k%0d_data", k),  data_per,      dv[idx]);
      if (k > 0 && k < 4) req[(idx + NUM_REQ - 1) % NUM_REQ] = 1'b1;
      tick;
      check($sformatf("rr_k%0d_done", k),  32'(done),     32'(1 << idx));
      tick;
      check($sformatf("rr_k%0d_gap_send", k), 32'(send_per), 32'h0);
      check($sformatf("rr_k%0d_gap_grant", k), 32'(grant),   32'h0);
      req[idx] = 1'b0;
      if (idx == 3) req = 4'b0011;
      if (k == 4)   req = '0;
      tick;
    end
    check("rr_end_busy", 32'(busy),  32'h0);
    check("rr_end_data", data_per,   dv[0]);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/periph_send_arbiter.md
Name: periph_send_arbiter

Overview:
- Shares one synchronous-communication peripheral receive port (SEND strobe plus 32-bit data) among NUM_REQ requesters.
- Arbitrates round-robin, latches the winner's word, and drives the peripheral's SEND/data for HOLD_CYCLES.
- Inserts GAP_CYCLES of SEND low between words so the peripheral FSM returns to its not-receiving state.
- Sits between the requester FSMs and the peripheral, in the same clock domain.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_W, 32: transfer word width.
- HOLD_CYCLES, 1: cycles send_per is held high per word, 1..15.
- GAP_CYCLES, 1: cycles send_per is held low after each word, 1..15. 0 is illegal.

Ports:
- clk_arb  in  1  clock; all state changes on its rising edge.
- rst_arb  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  level request, one bit per requester.
- req_data  in  NUM_REQ*DATA_W  packed words; requester i occupies bits [i*DATA_W +: DATA_W].
- grant  out  NUM_REQ  one-hot; high while that requester's word is on the bus.
- done  out  NUM_REQ  one-hot, single-cycle pulse marking completion.
- busy  out  1  high in any state other than IDLE.
- send_per  out  1  SEND strobe to the peripheral.
- data_per  out  DATA_W  data to the peripheral.

Behaviour:
- Clocking and reset: one clock, clk_arb. Reset rst_arb is asynchronous and active-low.
- While rst_arb=0:
  - state=IDLE, rr_ptr=0, hold and gap counters=0.
  - grant=0, done=0, busy=0, send_per=0, data_per=0.
  - Asserting reset mid-transfer forces these values immediately. The in-flight word is lost and no done is issued.
- States:
  - IDLE -> XFER when any req bit is 1.
  - XFER -> GAP after HOLD_CYCLES cycles.
  - GAP -> XFER at the last GAP cycle if any req is 1; otherwise GAP -> IDLE.
- Arbitration: evaluated combinationally in IDLE and in the last GAP cycle.
  - Winner is the first set req bit found searching from index rr_ptr upward, with wrap-around modulo NUM_REQ.
  - On grant, rr_ptr <= winner+1, wrapping to 0 after NUM_REQ-1.
- Latency: req[i] high in IDLE cycle t gives:
  - cycle t+1: grant[i]=1, send_per=1, data_per=req_data[i] (latched at the t edge).
  - send_per and grant stay high through cycle t+HOLD_CYCLES.
  - done[i]=1 in cycle t+HOLD_CYCLES only (the last XFER cycle).
- GAP: send_per=0, grant=0.
  - data_per holds the last word through GAP and IDLE, until the next grant. The peripheral samples data one cycle after SEND, so data_per must not be cleared early.
- Throughput: back-to-back words take HOLD_CYCLES+GAP_CYCLES cycles each.
- Requester contract:
  - Hold req and req_data stable until done.
  - Deassert req in the cycle after done; otherwise a new request is registered.
  - Because GAP_CYCLES>=1, a req dropped after done is never re-granted.
- req dropped mid-XFER: the word is already latched, so the transfer completes and done still pulses.
- req_data changes mid-XFER are ignored.
- Simultaneous requests: exactly one grant per arbitration. Losers wait; no request is lost while it is held.
- Counters are $clog2-sized with saturation-free wrap. Hold and gap counters reset to 0 on state entry.

Optional Feature:
- Macro: PERIPH_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. rr_ptr is not implemented and is treated as 0.
- Undefined: round-robin as specified above (the default).
- All other timing is identical in both modes.

Decomposition:
- Shared package periph_arb_pkg:
  - state enum {IDLE, XFER, GAP}, 2 bits.
  - default-width constants DATA_W_DEF=32.
  - function rr_pick(req, ptr) returning a one-hot vector.
- Sub-module periph_rr_picker: combinational rotate / priority-encode / rotate-back. It is bypassed by the macro.
- The top module holds the FSM, counters, data latch and rr_ptr.

Test Plan:
- Reset: rst_arb=0 mid-XFER with send_per=1 -> send_per, grant, done, busy and data_per all read 0 in the same cycle. After release, the first grant goes to req[0] when req=4'b1111.
- Single transfer: HOLD=2, GAP=1, req[2]=1 with data 32'hDEADBEEF at cycle 0:
  - send_per=1 in cycles 1-2, data_per=DEADBEEF.
  - done[2] in cycle 2; req dropped in cycle 3.
  - send_per=0 in cycle 3; IDLE in cycle 4; data_per still DEADBEEF.
- Round-robin: req=4'b1111 held, each requester dropping and re-raising req after its done -> grant order 0,1,2,3,0, each separated by HOLD+GAP cycles.
- Wrap-around: after granting 3, req=4'b0011 -> next grant is 0, not 1.
- Fixed priority (macro defined): req=4'b1010 held -> grant always 1. Requester 3 is granted only after req[1] drops.
- Mid-transfer changes: req dropped and req_data changed during XFER -> the originally latched word is driven for the full hold, and done still pulses.
